fft_32p_input_loader: RTL and testbench
=======================================

Name: fft_32p_input_loader

Overview:
Upstream input stage for the 32-point, 32-bit FFT core. It accepts a serial sample stream over a valid/ready handshake and collects samples into a ping-pong pair of frame buffers. Each sample is written at its bit-reversed slot, so a completed frame is presented as one parallel bus. Slot k of the bus connects directly to FFT input din<k>; slot k carries natural-order sample bitrev(k).

Parameters:
DATA_W, 32, sample width in bits (two's complement, passed through unmodified)
LOG2N, 5, log2 of frame length; N = 2**LOG2N = 32; supported range 3..6

Ports:
clk  input  1  single clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset; low clears all state immediately
in_data  input  DATA_W  serial sample, natural time order
in_valid  input  1  in_data valid this cycle
in_ready  output  1  registered; loader can accept a sample
flush  input  1  synchronous; discard partially filled write bank
frame_data  output  N*DATA_W  parallel frame; slot k = bits [DATA_W*k+DATA_W-1 : DATA_W*k] = sample bitrev(k)
frame_valid  output  1  frame_data holds a complete frame
frame_ready  input  1  consumer (FFT core) takes the frame this cycle
fill_level  output  LOG2N+1  samples held in the current write bank, 0..N

Behaviour:
- Reset values: in_ready=1, frame_valid=0, frame_data=0, fill_level=0. Both banks are cleared. The write pointer selects bank A.
- Accept: a sample is accepted on a cycle with in_valid & in_ready & !flush. Accepted sample n (0..N-1 within the frame) is stored at write-bank slot bitrev_LOG2N(n). wr_cnt then increments.
- Frame complete: the cycle that accepts sample N-1 marks the write bank full.
  - Swap condition: the read side is free, i.e. frame_valid=0, or frame_valid & frame_ready in that same cycle.
  - If the swap condition holds, the banks swap and frame_valid=1 on the next cycle. Latency is 1 cycle from the last accepted sample to frame_valid.
  - On a swap, wr_cnt returns to 0 and in_ready stays 1.
  - If the swap condition does not hold, in_ready=0 from the next cycle. The full bank waits.
- Pending swap: while the write bank is full and frame_valid=1, a frame_ready handshake swaps the banks on the following cycle. frame_valid stays 1 (new frame), and in_ready returns to 1 in that same following cycle.
- Frame handshake with no full bank waiting: frame_valid drops to 0 on the next cycle. frame_data holds its last value.
- Stability: frame_data must not change while frame_valid=1 and frame_ready=0.
- Back-to-back operation: when the last sample and the frame handshake coincide, frame_valid stays high with no bubble. Continuous input at 1 sample/cycle is sustained whenever frame_ready is asserted at least once per N cycles.
- flush:
  - Clears wr_cnt and fill_level to 0 on the next cycle.
  - The presented frame and any full bank waiting to swap are unaffected.
  - flush has priority over a simultaneous sample; that sample is dropped.
  - flush while the write bank is full has no effect.
- fill_level reports N while a full bank is waiting, otherwise wr_cnt.
- Reset mid-operation: the partial frame and the presented frame are both lost. After reset deasserts, the first accepted sample is n=0.
- frame_valid asserted with frame_ready=0 and in_valid=0 holds indefinitely. There is no timeout.

Optional Feature:
FFT_IN_FRAME_CNT_EN
- Defined: adds output port frame_cnt (16 bits), reset to 0. It increments on every frame_valid & frame_ready handshake and wraps 0xFFFF->0x0000.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Continuous fill: after reset, feed in_data=0x100+n for n=0..31 on 32 consecutive cycles, frame_ready=0 -> frame_valid=1 the cycle after the 32nd sample. Slot0=0x100, slot1=0x110, slot2=0x108, slot3=0x118, slot31=0x11F.
2. Backpressure: frame_ready=0, offer 70 samples continuously -> exactly 64 accepted and in_ready=0 from the cycle after the 64th. frame_data stays frame 1 throughout. A single frame_ready pulse presents frame 2 (slot0=sample 32) on the next cycle, and in_ready=1 the same cycle.
3. Flush: accept 10 samples, assert flush together with in_valid -> fill_level=0 the next cycle and that sample is dropped. The next 32 samples form a frame whose slot0 is the first post-flush sample.
4. Back-to-back: the 32nd sample of frame 2 coincides with frame_ready for frame 1 -> frame_valid stays 1 with no low cycle, frame 2 appears the next cycle, and in_ready never drops.
5. Async reset: drop reset mid-clock with frame_valid=1 and 20 samples buffered -> frame_valid=0, frame_data=0, fill_level=0 immediately. After release, in_ready=1 and a fresh 32-sample frame is correct.
6. FFT_IN_FRAME_CNT_EN defined: 3 frame handshakes -> frame_cnt=3. Preload to 0xFFFF by 65535 handshakes (or force), then one more -> frame_cnt=0.

Source files
------------

// File: rtl/fft_32p_input_loader.sv
// Serial-to-parallel ping-pong frame loader for the 32-point FFT core; samples land bit-reversed.
// Optional FFT_IN_FRAME_CNT_EN adds a 16-bit frame_cnt handshake counter output.
module fft_32p_input_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LOG2N  = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    output logic [(1<<LOG2N)*DATA_W-1:0]    frame_data,
    output logic                            frame_valid,
    input  logic                            frame_ready,
`ifdef FFT_IN_FRAME_CNT_EN
    output logic [15:0]                     frame_cnt,
`endif
    output logic [LOG2N:0]                  fill_level
);

    localparam int unsigned N = 1 << LOG2N;

    logic [DATA_W-1:0] r_bank [2][N];
    logic              r_wr_sel;
    logic [LOG2N-1:0]  r_wr_cnt;
    logic              r_full;
    logic              r_frame_valid;
    logic              r_in_ready;

    logic              w_wr_sel_nxt;
    logic [LOG2N-1:0]  w_wr_cnt_nxt;
    logic              w_full_nxt;
    logic              w_frame_valid_nxt;
    logic              w_in_ready_nxt;

    logic              w_rd_sel;
    logic              w_accept;
    logic              w_last;
    logic              w_frame_hs;
    logic              w_rd_free;
    logic [LOG2N-1:0]  w_slot;

    assign w_rd_sel   = ~r_wr_sel;
    assign w_accept   = in_valid & r_in_ready & ~flush;
    assign w_last     = w_accept & (r_wr_cnt == LOG2N'(N - 1));
    assign w_frame_hs = r_frame_valid & frame_ready;
    assign w_rd_free  = ~r_frame_valid | frame_ready;

    always_comb begin
        w_slot = '0;
        for (int i = 0; i < LOG2N; i++) begin
            w_slot[i] = r_wr_cnt[LOG2N-1-i];
        end
    end

    // r_full only ever sets while a frame is presented, so a pending swap waits on frame_ready.
    always_comb begin
        w_wr_sel_nxt      = r_wr_sel;
        w_wr_cnt_nxt      = r_wr_cnt;
        w_full_nxt        = r_full;
        w_frame_valid_nxt = r_frame_valid;
        w_in_ready_nxt    = r_in_ready;
        if (w_last) begin
            w_wr_cnt_nxt = '0;
            if (w_rd_free) begin
                w_wr_sel_nxt      = ~r_wr_sel;
                w_frame_valid_nxt = 1'b1;
            end else begin
                w_full_nxt     = 1'b1;
                w_in_ready_nxt = 1'b0;
            end
        end else if (r_full) begin
            if (w_frame_hs) begin
                w_wr_sel_nxt   = ~r_wr_sel;
                w_full_nxt     = 1'b0;
                w_in_ready_nxt = 1'b1;
            end
        end else begin
            if (w_frame_hs) begin
                w_frame_valid_nxt = 1'b0;
            end
            if (flush) begin
                w_wr_cnt_nxt = '0;
            end else if (w_accept) begin
                w_wr_cnt_nxt = r_wr_cnt + LOG2N'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_sel      <= 1'b0;
            r_wr_cnt      <= '0;
            r_full        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_in_ready    <= 1'b1;
        end else begin
            r_wr_sel      <= w_wr_sel_nxt;
            r_wr_cnt      <= w_wr_cnt_nxt;
            r_full        <= w_full_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_in_ready    <= w_in_ready_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    r_bank[b][k] <= '0;
                end
            end
        end else if (w_accept) begin
            r_bank[r_wr_sel][w_slot] <= in_data;
        end
    end

    always_comb begin
        frame_data = '0;
        for (int k = 0; k < N; k++) begin
            frame_data[k*DATA_W +: DATA_W] = r_bank[w_rd_sel][k];
        end
    end

    assign frame_valid = r_frame_valid;
    assign in_ready    = r_in_ready;
    assign fill_level  = r_full ? (LOG2N+1)'(N) : {1'b0, r_wr_cnt};

`ifdef FFT_IN_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_hs) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_fft_32p_input_loader.sv
// Scoreboard bench for fft_32p_input_loader: expected frames are queued as samples are driven.
module tb_fft_32p_input_loader;

    localparam int DW = 32;
    localparam int LG = 5;
    localparam int N  = 1 << LG;

    logic              clk;
    logic              reset;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [N*DW-1:0]   frame_data;
    logic              frame_valid;
    logic              frame_ready;
    logic [LG:0]       fill_level;
`ifdef FFT_IN_FRAME_CNT_EN
    logic [15:0]       frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]   smp[$];
    logic [N*DW-1:0] exp_q[$];
    logic [N*DW-1:0] exp_f;
    logic [N*DW-1:0] saved_f;
    int              k;

    fft_32p_input_loader #(
        .DATA_W(DW),
        .LOG2N (LG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
`ifdef FFT_IN_FRAME_CNT_EN
        .frame_cnt  (frame_cnt),
`endif
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int tb_bitrev(input int v);
        int r = 0;
        for (int i = 0; i < LG; i++) begin
            if (((v >> i) & 1) != 0) r |= 1 << (LG - 1 - i);
        end
        return r;
    endfunction

    function automatic int first_diff(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        for (int s = 0; s < N; s++) begin
            if (a[s*DW +: DW] !== b[s*DW +: DW]) return s;
        end
        return 0;
    endfunction

    function automatic logic [N*DW-1:0] pop_exp();
        logic [N*DW-1:0] f = 'x;
        if (exp_q.size() != 0) f = exp_q.pop_front();
        return f;
    endfunction

    // Offers one sample for one cycle; in_valid is left high for streaming.
    task automatic drive(input logic [DW-1:0] d, input bit exp_acc);
        logic [N*DW-1:0] f;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        if (exp_acc) begin
            smp.push_back(d);
            if (smp.size() == N) begin
                f = '0;
                for (int s = 0; s < N; s++) f[s*DW +: DW] = smp[tb_bitrev(s)];
                exp_q.push_back(f);
                smp.delete();
            end
        end
    endtask

    task automatic do_reset();
        in_valid    = 1'b0;
        flush       = 1'b0;
        frame_ready = 1'b0;
        reset       = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        smp.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (frame_valid !== 1'b0) begin errors++;
            $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
        checks++; if (frame_data !== '0) begin errors++;
            $display("FAIL reset_frame_data: slot0 got %h want 0", frame_data[DW-1:0]); end
        checks++; if (fill_level !== '0) begin errors++;
            $display("FAIL reset_fill_level: got %0d want 0", fill_level); end
        reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int n = 0; n < N; n++) begin
            drive(32'h100 + n, 1'b1);
            if (n == 9) begin
                checks++; if (fill_level !== 6'd10) begin errors++;
                    $display("FAIL fill_level10: got %0d want 10", fill_level); end
            end
            if (n == N - 2) begin
                checks++; if (frame_valid !== 1'b0) begin errors++;
                    $display("FAIL fill_early_valid: got %b want 0", frame_valid); end
            end
        end
        in_valid = 1'b0;
        checks++; if (frame_valid !== 1'b1) begin errors++;
            $display("FAIL fill_valid: got %b want 1", frame_valid); end
        exp_f = pop_exp();
        checks++; if (frame_data !== exp_f) begin errors++; k = first_diff(frame_data, exp_f);
            $display("FAIL fill_frame: slot %0d got %h want %h", k,
                     frame_data[k*DW +: DW], exp_f[k*DW +: DW]); end
        checks++; if (frame_data[0*DW +: DW] !== 32'h100) begin errors++;
            $display("FAIL fill_slot0: got %h want 100", frame_data[0*DW +: DW]); end
        checks++; if (frame_data[1*DW +: DW] !== 32'h110) begin errors++;
            $display("FAIL fill_slot1: got %h want 110", frame_data[1*DW +: DW]); end
        checks++; if (frame_data[2*DW +: DW] !== 32'h108) begin errors++;
            $display("FAIL fill_slot2: got %h want 108", frame_data[2*DW +: DW]); end
        checks++; if (frame_data[3*DW +: DW] !== 32'h118) begin errors++;
            $display("FAIL fill_slot3: got %h want 118", frame_data[3*DW +: DW]); end
        checks++; if (frame_data[31*DW +: DW] !== 32'h11F) begin errors++;
            $display("FAIL fill_slot31: got %h want 11f", frame_data[31*DW +: DW]); end
        checks++; if (in_ready !== 1'b1 || fill_level !== '0) begin errors++;
            $display("FAIL fill_after: in_ready %b fill %0d want 1 0", in_ready, fill_level); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 70; i++) begin
            drive(32'h200 + i, i < 64);
            checks++; if (in_ready !== (i < 63)) begin errors++;
                $display("FAIL bp_in_ready[%0d]: got %b want %b", i, in_ready, (i < 63)); end
            if (i == 31) begin
                saved_f = pop_exp();
                checks++; if (frame_data !== saved_f) begin errors++;
                    k = first_diff(frame_data, saved_f);
                    $display("FAIL bp_frame1: slot %0d got %h want %h", k,
                             frame_data[k*DW +: DW], saved_f[k*DW +: DW]); end
            end
        end
        in_valid = 1'b0;
        checks++; if (frame_data !== saved_f || frame_valid !== 1'b1) begin errors++;
            $display("FAIL bp_stable: valid %b slot0 %h want 1 %h", frame_valid,
                     frame_data[DW-1:0], saved_f[DW-1:0]); end
        checks++; if (fill_level !== 6'd32) begin errors++;
            $display("FAIL bp_fill_full: got %0d want 32", fill_level); end
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        exp_f = pop_exp();
        checks++; if (frame_valid !== 1'b1 || frame_data !== exp_f) begin errors++;
            k = first_diff(frame_data, exp_f);
            $display("FAIL bp_frame2: valid %b slot %0d got %h want %h", frame_valid, k,
                     frame_data[k*DW +: DW], exp_f[k*DW +: DW]); end
        checks++; if (frame_data[DW-1:0] !== 32'h220) begin errors++;
            $display("FAIL bp_slot0: got %h want 220", frame_data[DW-1:0]); end
        checks++; if (in_ready !== 1'b1 || fill_level !== '0) begin errors++;
            $display("FAIL bp_resume: in_ready %b fill %0d want 1 0", in_ready, fill_level); end
    endtask

    task automatic test_flush();
        saved_f = frame_data;
        for (int i = 0; i < 10; i++) drive(32'h300 + i, 1'b1);
        checks++; if (fill_level !== 6'd10) begin errors++;
            $display("FAIL flush_pre_fill: got %0d want 10", fill_level); end
        flush = 1'b1;
        drive(32'hDEAD, 1'b0);
        flush = 1'b0;
        smp.delete();
        checks++; if (fill_level !== '0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL flush_clear: fill %0d in_ready %b want 0 1", fill_level, in_ready); end
        for (int i = 0; i < N; i++) drive(32'h400 + i, 1'b1);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || fill_level !== 6'd32) begin errors++;
            $display("FAIL flush_wait: in_ready %b fill %0d want 0 32", in_ready, fill_level); end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (fill_level !== 6'd32 || in_ready !== 1'b0) begin errors++;
            $display("FAIL flush_full: fill %0d in_ready %b want 32 0", fill_level, in_ready); end
        checks++; if (frame_data !== saved_f || frame_valid !== 1'b1) begin errors++;
            $display("FAIL flush_presented: valid %b slot0 %h want 1 %h", frame_valid,
                     frame_data[DW-1:0], saved_f[DW-1:0]); end
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        exp_f = pop_exp();
        checks++; if (frame_data !== exp_f) begin errors++; k = first_diff(frame_data, exp_f);
            $display("FAIL flush_frame: slot %0d got %h want %h", k,
                     frame_data[k*DW +: DW], exp_f[k*DW +: DW]); end
        checks++; if (frame_data[DW-1:0] !== 32'h400) begin errors++;
            $display("FAIL flush_slot0: got %h want 400", frame_data[DW-1:0]); end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) begin
                frame_ready = (i == N - 1);
                drive(32'h500 + f * 32'h100 + i, 1'b1);
                checks++; if (in_ready !== 1'b1 || frame_valid !== 1'b1) begin errors++;
                    $display("FAIL b2b_flow[%0d][%0d]: in_ready %b valid %b want 1 1", f, i,
                             in_ready, frame_valid); end
            end
            frame_ready = 1'b0;
            exp_f = pop_exp();
            checks++; if (frame_data !== exp_f) begin errors++; k = first_diff(frame_data, exp_f);
                $display("FAIL b2b_frame[%0d]: slot %0d got %h want %h", f, k,
                         frame_data[k*DW +: DW], exp_f[k*DW +: DW]); end
        end
        in_valid    = 1'b0;
        saved_f     = frame_data;
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        checks++; if (frame_valid !== 1'b0 || frame_data !== saved_f) begin errors++;
            $display("FAIL b2b_drain: valid %b slot0 %h want 0 %h", frame_valid,
                     frame_data[DW-1:0], saved_f[DW-1:0]); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < N; i++) drive(32'h700 + i, 1'b1);
        exp_f = pop_exp();
        checks++; if (frame_valid !== 1'b1 || frame_data !== exp_f) begin errors++;
            $display("FAIL ar_pre_frame: valid %b slot0 %h want 1 %h", frame_valid,
                     frame_data[DW-1:0], exp_f[DW-1:0]); end
        for (int i = 0; i < 20; i++) drive(32'h7A0 + i, 1'b1);
        in_valid = 1'b0;
        checks++; if (fill_level !== 6'd20) begin errors++;
            $display("FAIL ar_pre_fill: got %0d want 20", fill_level); end
        #3;
        reset = 1'b0;
        #1;
        checks++; if (frame_valid !== 1'b0 || frame_data !== '0 || fill_level !== '0) begin
            errors++;
            $display("FAIL ar_immediate: valid %b slot0 %h fill %0d want 0 0 0", frame_valid,
                     frame_data[DW-1:0], fill_level); end
        smp.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL ar_in_ready: got %b want 1", in_ready); end
        for (int i = 0; i < N; i++) drive(32'h800 + i, 1'b1);
        in_valid = 1'b0;
        exp_f = pop_exp();
        checks++; if (frame_valid !== 1'b1 || frame_data !== exp_f) begin errors++;
            k = first_diff(frame_data, exp_f);
            $display("FAIL ar_frame: valid %b slot %0d got %h want %h", frame_valid, k,
                     frame_data[k*DW +: DW], exp_f[k*DW +: DW]); end
    endtask

`ifdef FFT_IN_FRAME_CNT_EN
    task automatic test_frame_cnt();
        do_reset();
        checks++; if (frame_cnt !== 16'd0) begin errors++;
            $display("FAIL cnt_reset: got %0d want 0", frame_cnt); end
        for (int h = 0; h < 3; h++) begin
            for (int i = 0; i < N; i++) drive(32'h900 + h * 32 + i, 1'b1);
            in_valid = 1'b0;
            exp_f = pop_exp();
            checks++; if (frame_data !== exp_f) begin errors++;
                $display("FAIL cnt_frame[%0d]: slot0 got %h want %h", h, frame_data[DW-1:0],
                         exp_f[DW-1:0]); end
            frame_ready = 1'b1;
            @(posedge clk);
            #1;
            frame_ready = 1'b0;
        end
        checks++; if (frame_cnt !== 16'd3) begin errors++;
            $display("FAIL cnt_three: got %0d want 3", frame_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_async_reset();
`ifdef FFT_IN_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
